// File: rtl/perf_bus_bridge.sv
// perf_bus_bridge: single-beat CPU bus into a 256-byte performance counter window.
// Writes to the ctrl register go out as a one-cycle strobe. Reads of a 64-bit
// counter's low word follow a hi/lo/hi sampling sequence, retried until both hi
// samples agree, so the low word returned always pairs with a stable high word.
// That high word is kept in a shadow register for the later hi-word read.
module perf_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  perf_addr_o,
  output logic [2:0]  perf_wdata_o,
  output logic        perf_w_en_o,
  input  logic [31:0] perf_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_H1  = 3'd1,
    S_L   = 3'd2,
    S_H2  = 3'd3,
    S_CHK = 3'd4,
    RESP  = 3'd5
  } state_e;

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_MC_LO = 8'h04;
  localparam logic [7:0] OFF_MC_HI = 8'h08;
  localparam logic [7:0] OFF_IR_LO = 8'h10;
  localparam logic [7:0] OFF_IR_HI = 8'h14;
  localparam logic [7:0] HI_STEP   = 8'h04;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  perf_addr_q, perf_addr_d;
  logic [2:0]  perf_wdata_q, perf_wdata_d;
  logic        perf_w_en_q, perf_w_en_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] mc_hi_q, mc_hi_d;
  logic [31:0] ir_hi_q, ir_hi_d;
  logic [31:0] h1_q, h1_d;
  logic [31:0] lo_q, lo_d;
  logic [7:0]  off_q, off_d;

  logic        hit;
  logic        chk_ok;

  // Only the low three write-data bits reach the counter block.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:3];

  assign hit = (addr_i[31:8] == BASE_ADDR[31:8]);

  // Next-state and datapath decode; the second hi sample is taken straight
  // from perf_rdata_i in S_CHK so a clean read acks in that same cycle.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    ack_d        = 1'b0;
    rdata_d      = rdata_q;
    perf_addr_d  = perf_addr_q;
    perf_wdata_d = perf_wdata_q;
    perf_w_en_d  = 1'b0;
    ctrl_d       = ctrl_q;
    mc_hi_d      = mc_hi_q;
    ir_hi_d      = ir_hi_q;
    h1_d         = h1_q;
    lo_d         = lo_q;
    off_d        = off_q;
    chk_ok       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          off_d   = addr_i[7:0];
          state_d = RESP;
          ack_d   = 1'b1;
          if (we_i) begin
            if (hit && addr_i[7:0] == OFF_CTRL) begin
              perf_w_en_d  = 1'b1;
              perf_addr_d  = OFF_CTRL;
              perf_wdata_d = wdata_i[2:0];
              ctrl_d       = wdata_i[1:0];
            end
          end else if (!hit) begin
            rdata_d = '0;
          end else begin
            case (addr_i[7:0])
              OFF_CTRL:  rdata_d = {30'b0, ctrl_q};
              OFF_MC_HI: rdata_d = mc_hi_q;
              OFF_IR_HI: rdata_d = ir_hi_q;
              OFF_MC_LO, OFF_IR_LO: begin
                state_d     = S_H1;
                ack_d       = 1'b0;
                perf_addr_d = addr_i[7:0] + HI_STEP;
              end
              default:   rdata_d = '0;
            endcase
          end
        end
      end
      S_H1: begin
        state_d     = S_L;
        perf_addr_d = off_q;
      end
      S_L: begin
        h1_d        = perf_rdata_i;
        state_d     = S_H2;
        perf_addr_d = off_q + HI_STEP;
      end
      S_H2: begin
        lo_d    = perf_rdata_i;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (perf_rdata_i == h1_q) begin
          chk_ok  = 1'b1;
          rdata_d = lo_q;
          state_d = IDLE;
          if (off_q[4]) ir_hi_d = perf_rdata_i;
          else          mc_hi_d = perf_rdata_i;
        end else begin
          // High word moved under us: resample the low word against the newer high word.
          h1_d        = perf_rdata_i;
          perf_addr_d = off_q;
          state_d     = S_L;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset takes effect immediately and drops any sequence in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      perf_addr_q  <= OFF_MC_LO;
      perf_wdata_q <= '0;
      perf_w_en_q  <= 1'b0;
      ctrl_q       <= '0;
      mc_hi_q      <= '0;
      ir_hi_q      <= '0;
      h1_q         <= '0;
      lo_q         <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      perf_addr_q  <= perf_addr_d;
      perf_wdata_q <= perf_wdata_d;
      perf_w_en_q  <= perf_w_en_d;
      ctrl_q       <= ctrl_d;
      mc_hi_q      <= mc_hi_d;
      ir_hi_q      <= ir_hi_d;
      h1_q         <= h1_d;
      lo_q         <= lo_d;
      off_q        <= off_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign ack_o        = ack_q | chk_ok;
  assign rdata_o      = chk_ok ? lo_q : rdata_q;
  assign perf_addr_o  = perf_addr_q;
  assign perf_wdata_o = perf_wdata_q;
  assign perf_w_en_o  = perf_w_en_q;

endmodule

// File: tb/tb_perf_bus_bridge.sv
// Testbench for perf_bus_bridge: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the perf window.
module tb_perf_bus_bridge;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] perf_rdata_i = '0;
  logic        ready_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic [7:0]  perf_addr_o;
  logic [2:0]  perf_wdata_o;
  logic        perf_w_en_o;

  // Counter block contents: index 0 = mcycle, 1 = instret.
  logic [63:0] cnt [2];

  // Reference model of what software should observe.
  logic [1:0]  m_ctrl;
  logic [31:0] m_hi [2];
  logic [7:0]  m_paddr;
  int          exp_wen = 0;
  int          wen_seen = 0;

  int n_cmp = 0;
  int n_err = 0;

  perf_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .perf_addr_o  (perf_addr_o),
    .perf_wdata_o (perf_wdata_o),
    .perf_w_en_o  (perf_w_en_o),
    .perf_rdata_i (perf_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Counter block: offset presented in one cycle returns its data in the next.
  always @(posedge clk_i) begin
    case (perf_addr_o)
      8'h04:   perf_rdata_i <= cnt[0][31:0];
      8'h08:   perf_rdata_i <= cnt[0][63:32];
      8'h10:   perf_rdata_i <= cnt[1][31:0];
      8'h14:   perf_rdata_i <= cnt[1][63:32];
      default: perf_rdata_i <= 32'h0;
    endcase
  end

  // Count every ctrl strobe cycle the DUT emits.
  always @(negedge clk_i) if (perf_w_en_o === 1'b1) wen_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction, entered and left just after a falling edge.
  // chg_sel >= 0 swaps that counter to chg_val during cycle A+2.
  // poke drives a ctrl write while the bridge is busy; it must be ignored.
  task automatic do_op(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                       input int chg_sel, input logic [63:0] chg_val, input logic poke);
    int   n;
    logic ctrl_hit;
    ctrl_hit = we && (addr == BASE);
    check({tag, ".ready"}, ready_o, 1);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    n = 1;
    while (n <= 16) begin
      if (chg_sel >= 0 && n == 2) cnt[chg_sel] = chg_val;
      if (poke && n <= 3) begin
        check({tag, ".busy_ready"}, ready_o, 0);
        req_i = 1'b1; we_i = 1'b1; addr_i = BASE; wdata_i = 32'h7;
      end else begin
        req_i = 1'b0;
      end
      if (ctrl_hit && n == 1) begin
        check({tag, ".wen"}, perf_w_en_o, 1);
        check({tag, ".pwdata"}, perf_wdata_o, wdata[2:0]);
        check({tag, ".paddr_wr"}, perf_addr_o, 8'h00);
      end
      if (ack_o === 1'b1) break;
      @(negedge clk_i);
      n++;
    end
    req_i = 1'b0;
    check({tag, ".lat"}, n, exp_lat);
    if (!we && n <= 16) check({tag, ".rdata"}, rdata_o, exp_rdata);
    @(negedge clk_i);
    check({tag, ".ack_pulse"}, ack_o, 0);
    check({tag, ".wen_count"}, wen_seen, exp_wen);
    check({tag, ".paddr"}, perf_addr_o, m_paddr);
  endtask

  initial begin
    int          kind;
    int          sel;
    logic [31:0] d;
    logic [31:0] a;
    logic [7:0]  off;
    logic [7:0]  lo_off;
    logic [63:0] nv;

    cnt[0] = '0; cnt[1] = '0;
    m_ctrl = '0; m_hi[0] = '0; m_hi[1] = '0; m_paddr = 8'h04;

    // Reset values.
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst.ready", ready_o, 1);
    check("rst.ack", ack_o, 0);
    check("rst.rdata", rdata_o, 0);
    check("rst.wen", perf_w_en_o, 0);
    check("rst.paddr", perf_addr_o, 8'h04);
    check("rst.pwdata", perf_wdata_o, 0);
    rst_ni = 1'b1;

    // Ctrl write then readback.
    m_ctrl = 2'd1; exp_wen++; m_paddr = 8'h00;
    do_op("ctrl_wr1", 1, BASE, 32'h1, 1, 0, -1, 0, 0);
    do_op("ctrl_rd1", 0, BASE, 0, 1, 32'h1, -1, 0, 0);

    // Steady mcycle: lo read acks at A+4, hi shadow follows.
    cnt[0] = 64'h0000_0005_0000_1000;
    m_hi[0] = 32'h5; m_paddr = 8'h08;
    do_op("mc_lo_steady", 0, BASE | 32'h04, 0, 4, 32'h0000_1000, -1, 0, 0);
    do_op("mc_hi_steady", 0, BASE | 32'h08, 0, 1, 32'h5, -1, 0, 0);

    // Carry between hi samples: retry acks at A+7; busy requests ignored.
    cnt[0] = 64'h0000_0005_FFFF_FFFE;
    m_hi[0] = 32'h6; m_paddr = 8'h08;
    do_op("mc_lo_carry", 0, BASE | 32'h04, 0, 7, 32'h2, 0, 64'h0000_0006_0000_0002, 1);
    do_op("mc_hi_carry", 0, BASE | 32'h08, 0, 1, 32'h6, -1, 0, 0);
    do_op("ctrl_rd_after_poke", 0, BASE, 0, 1, 32'h1, -1, 0, 0);

    // Unmapped offset, foreign base, non-ctrl write.
    do_op("rd_0c", 0, BASE | 32'h0C, 0, 1, 32'h0, -1, 0, 0);
    do_op("rd_foreign", 0, 32'h3000_0004, 0, 1, 32'h0, -1, 0, 0);
    do_op("wr_04", 1, BASE | 32'h04, 32'h3, 1, 0, -1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 6));
      d = $urandom;
      sel = int'($urandom_range(0, 1));
      lo_off = (sel == 1) ? 8'h10 : 8'h04;
      case (kind)
        0: begin
          m_ctrl = d[1:0]; exp_wen++; m_paddr = 8'h00;
          do_op("rnd_ctrl_wr", 1, BASE, d, 1, 0, -1, 0, 0);
        end
        1: do_op("rnd_ctrl_rd", 0, BASE, 0, 1, {30'b0, m_ctrl}, -1, 0, 0);
        2: begin
          cnt[sel] = {$urandom, $urandom};
          m_paddr = lo_off + 8'h04;
          if ($urandom_range(0, 2) == 0) begin
            nv = {cnt[sel][63:32] + 32'd1, $urandom};
            m_hi[sel] = nv[63:32];
            do_op("rnd_lo_carry", 0, {BASE[31:8], lo_off}, 0, 7, nv[31:0], sel, nv, 0);
          end else begin
            m_hi[sel] = cnt[sel][63:32];
            do_op("rnd_lo", 0, {BASE[31:8], lo_off}, 0, 4, cnt[sel][31:0], -1, 0, 0);
          end
        end
        3: do_op("rnd_hi", 0, {BASE[31:8], lo_off + 8'h04}, 0, 1, m_hi[sel], -1, 0, 0);
        4: begin
          off = 8'($urandom_range(0, 255));
          while (off inside {8'h00, 8'h04, 8'h08, 8'h10, 8'h14}) off = 8'($urandom_range(0, 255));
          do_op("rnd_unmapped", 0, {BASE[31:8], off}, 0, 1, 32'h0, -1, 0, 0);
        end
        5: begin
          a = {24'h30_0000 + 24'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
          do_op("rnd_foreign", 0, a, 0, 1, 32'h0, -1, 0, 0);
        end
        default: begin
          if (d[31]) a = {BASE[31:8], 8'($urandom_range(1, 255))};
          else       a = {24'h40_0000 + 24'($urandom_range(0, 255)), 8'h00};
          do_op("rnd_wr_other", 1, a, d, 1, 0, -1, 0, 0);
        end
      endcase
    end

    // Reset in the middle of a lo read: no ack, no strobe, reset values at once.
    cnt[0] = 64'h0000_0009_0000_0033;
    check("mid.ready", ready_o, 1);
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE | 32'h04;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid.ready_rst", ready_o, 1);
    check("mid.ack_rst", ack_o, 0);
    check("mid.rdata_rst", rdata_o, 0);
    check("mid.wen_rst", perf_w_en_o, 0);
    check("mid.paddr_rst", perf_addr_o, 8'h04);
    check("mid.pwdata_rst", perf_wdata_o, 0);
    m_ctrl = '0; m_hi[0] = '0; m_hi[1] = '0; m_paddr = 8'h04;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("mid.ack_hold", ack_o, 0);
    end
    check("mid.wen_count", wen_seen, exp_wen);
    rst_ni = 1'b1;
    do_op("post_rst_ctrl_rd", 0, BASE, 0, 1, 32'h0, -1, 0, 0);
    do_op("post_rst_mc_hi", 0, BASE | 32'h08, 0, 1, 32'h0, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
